// File: rtl/path_tracer_pkg.sv
// Shared constants for the path tracer: default sizing and the controller
// state encoding, kept here so debug logic can decode the state register.
package path_tracer_pkg;

    localparam int DEFAULT_MAX_NODES   = 16;
    localparam int DEFAULT_INDEX_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_COLLECT = 2'd1;
    localparam state_t S_EMIT    = 2'd2;
    localparam state_t S_FINISH  = 2'd3;

endpackage

// File: rtl/path_stack.sv
// Synchronous LIFO holding node indices while the predecessor chain is walked.
// The pointer alone decides which entries are live.
module path_stack #(
    parameter int MAX_NODES   = path_tracer_pkg::DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = path_tracer_pkg::DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [INDEX_WIDTH-1:0] push_data,
    output logic [INDEX_WIDTH-1:0] top,
    output logic [INDEX_WIDTH:0]   depth,
    output logic                   empty
);

    localparam int AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    logic [INDEX_WIDTH-1:0] mem_q [MAX_NODES];
    logic [INDEX_WIDTH:0]   ptr_q, ptr_d;
    logic [INDEX_WIDTH:0]   top_idx;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an empty pointer makes its contents irrelevant.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign top_idx = ptr_q - 1'b1;
    assign empty   = (ptr_q == '0);
    assign depth   = ptr_q;
    assign top     = empty ? '0 : mem_q[top_idx[AW-1:0]];

endmodule

// File: rtl/path_tracer.sv
// Walks the predecessor chain from destination back to source into a LIFO,
// then streams the path source-first over valid/ready.
module path_tracer
    import path_tracer_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [INDEX_WIDTH-1:0]             number_of_nodes,
    input  logic [INDEX_WIDTH*MAX_NODES-1:0]   prev_vector_flattened,
    input  logic                               start,
    input  logic [INDEX_WIDTH-1:0]             source,
    input  logic [INDEX_WIDTH-1:0]             destination,
    output logic                               busy,
    output logic [INDEX_WIDTH-1:0]             path_node,
    output logic                               path_valid,
    input  logic                               path_ready,
    output logic                               path_last,
    output logic [INDEX_WIDTH:0]               path_length,
    output logic                               done,
    output logic                               error
);

    // Predecessor value marking a node Dijkstra never reached.
    localparam logic [INDEX_WIDTH-1:0] UNVISITED = '1;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cur_q, cur_d;
    logic [INDEX_WIDTH-1:0] src_q, src_d;
    logic [INDEX_WIDTH:0]   length_q, length_d;
    logic                   error_q, error_d;

    logic                   stk_push, stk_pop, stk_clear;
    logic [INDEX_WIDTH-1:0] stk_top;
    logic [INDEX_WIDTH:0]   stk_depth;
    logic                   stk_empty;
    logic [INDEX_WIDTH-1:0] prev_of_cur;

    path_stack #(
        .MAX_NODES   (MAX_NODES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (cur_q),
        .top       (stk_top),
        .depth     (stk_depth),
        .empty     (stk_empty)
    );

    always_comb begin
        prev_of_cur = '0;
        for (int j = 0; j < MAX_NODES; j++) begin
            if (cur_q == INDEX_WIDTH'(j)) begin
                prev_of_cur = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign path_valid = (state_q == S_EMIT) && !stk_empty;
    assign path_node  = path_valid ? stk_top : '0;
    assign path_last  = path_valid && (stk_depth == (INDEX_WIDTH+1)'(1));
    assign path_length = length_q;
    assign done       = (state_q == S_FINISH);
    assign error      = done && error_q;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        src_d     = src_q;
        length_d  = length_q;
        error_d   = error_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d     = source;
                    cur_d     = destination;
                    length_d  = '0;
                    error_d   = 1'b0;
                    stk_clear = 1'b1;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Range check outranks the cycle guard; a push only happens when both pass.
                if (cur_q >= number_of_nodes) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else if (stk_depth == {1'b0, number_of_nodes}) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    stk_push = 1'b1;
                    if (cur_q == src_q) begin
                        length_d = stk_depth + 1'b1;
                        state_d  = S_EMIT;
                    end else if (prev_of_cur == UNVISITED) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        cur_d = prev_of_cur;
                    end
                end
            end
            S_EMIT: begin
                if (path_valid && path_ready) begin
                    stk_pop = 1'b1;
                    if (path_last) begin
                        error_d = 1'b0;
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            src_q    <= '0;
            length_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            src_q    <= src_d;
            length_q <= length_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_path_tracer.sv
// Directed and randomized checks of path_tracer against a queue-based model
// that walks the predecessor table and builds the path source-first.
module tb_path_tracer;

    localparam int MN  = 16;
    localparam int IW  = 4;
    localparam int UNV = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic [IW-1:0]     number_of_nodes;
    logic [IW*MN-1:0]  prev_vector_flattened;
    logic              start;
    logic [IW-1:0]     source;
    logic [IW-1:0]     destination;
    logic              busy;
    logic [IW-1:0]     path_node;
    logic              path_valid;
    logic              path_ready;
    logic              path_last;
    logic [IW:0]       path_length;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;
    int prev_tab[MN];
    int n_nodes;
    int exp_q[$];

    path_tracer #(.MAX_NODES(MN), .INDEX_WIDTH(IW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .number_of_nodes       (number_of_nodes),
        .prev_vector_flattened (prev_vector_flattened),
        .start                 (start),
        .source                (source),
        .destination           (destination),
        .busy                  (busy),
        .path_node             (path_node),
        .path_valid            (path_valid),
        .path_ready            (path_ready),
        .path_last             (path_last),
        .path_length           (path_length),
        .done                  (done),
        .error                 (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: follow predecessors from d, prepending each node, until s is reached.
    task automatic model(input int s, input int d, output bit err);
        int cur;
        exp_q.delete();
        err = 1'b0;
        cur = d;
        for (int step = 0; step <= n_nodes; step++) begin
            if (cur >= n_nodes || exp_q.size() == n_nodes) begin
                err = 1'b1;
                break;
            end
            exp_q.push_front(cur);
            if (cur == s) break;
            if (prev_tab[cur] == UNV) begin
                err = 1'b1;
                break;
            end
            cur = prev_tab[cur];
        end
        if (err) exp_q.delete();
    endtask

    task automatic drive_graph();
        number_of_nodes = IW'(n_nodes);
        for (int j = 0; j < MN; j++) prev_vector_flattened[IW*j +: IW] = IW'(prev_tab[j]);
    endtask

    task automatic set_scenario1();
        n_nodes = 10;
        for (int j = 0; j < MN; j++) prev_tab[j] = UNV;
        prev_tab[4] = 2;
        prev_tab[2] = 7;
        prev_tab[7] = 0;
        drive_graph();
    endtask

    // mode 0: ready always high, 1: random ready, 2: 3-cycle stall on beat 2 plus a stray start
    task automatic run_req(input int s, input int d, input int mode, input string name);
        bit   exp_err;
        int   got[$];
        int   collect = 0;
        int   stall_n = 0;
        bit   seen_done = 1'b0;
        bit   seen_valid = 1'b0;
        bit   stalled = 1'b0;
        bit   acc_nonlast = 1'b0;
        logic [IW-1:0] held_node = '0;
        logic held_last = 1'b0;
        int   exp_len;

        model(s, d, exp_err);
        exp_len = exp_err ? 0 : exp_q.size();
        drive_graph();
        @(negedge clock);
        source = IW'(s);
        destination = IW'(d);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            start = 1'b0;
            if (mode == 2 && path_valid && got.size() == 1 && stall_n < 3) begin
                path_ready = 1'b0;
                if (stall_n == 0) begin
                    start = 1'b1;
                    source = 4'd9;
                    destination = 4'd9;
                end
                stall_n++;
            end else if (mode == 1) begin
                path_ready = ($urandom_range(0, 3) != 0);
            end else begin
                path_ready = 1'b1;
            end

            if (stalled) begin
                check({name, "_hold_valid"}, path_valid, 1);
                check({name, "_hold_node"}, path_node, held_node);
                check({name, "_hold_last"}, path_last, held_last);
            end
            if (acc_nonlast) check({name, "_no_bubble"}, path_valid, 1);

            if (path_valid) begin
                if (!seen_valid) check({name, "_collect_cycles"}, collect, exp_len);
                seen_valid = 1'b1;
                if (path_ready) begin
                    got.push_back(int'(path_node));
                    check({name, "_last_flag"}, path_last, (got.size() == exp_len));
                    acc_nonlast = !path_last;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_node = path_node;
                    held_last = path_last;
                    acc_nonlast = 1'b0;
                end
            end else begin
                stalled = 1'b0;
                acc_nonlast = 1'b0;
                if (busy && !done) collect++;
            end

            if (done) begin
                seen_done = 1'b1;
                check({name, "_error"}, error, exp_err);
                check({name, "_length"}, path_length, exp_len);
            end
            @(negedge clock);
        end
        start = 1'b0;

        check({name, "_done_seen"}, seen_done, 1);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_idle"}, busy, 0);
        check({name, "_length_held"}, path_length, exp_len);
        check({name, "_beats"}, got.size(), exp_len);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check({name, "_node"}, got[i], exp_q[i]);
        if (mode == 2) check({name, "_stalls"}, stall_n, 3);
    endtask

    initial begin
        int perm[MN];
        int plen;
        int k;
        int t;
        int s;
        int d;
        int waited;

        reset = 1'b0;
        start = 1'b0;
        path_ready = 1'b0;
        source = '0;
        destination = '0;
        set_scenario1();
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", path_valid, 0);
        check("rst_node", path_node, 0);
        check("rst_last", path_last, 0);
        check("rst_length", path_length, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        #21;
        reset = 1'b1;

        // Basic chain 0 -> 7 -> 2 -> 4.
        set_scenario1();
        run_req(0, 4, 0, "chain");

        // Source equals destination; prev[3] must not matter.
        prev_tab[3] = 5;
        run_req(3, 3, 0, "self");

        // Unreachable: 5 -> 9 -> unvisited.
        set_scenario1();
        prev_tab[5] = 9;
        prev_tab[9] = UNV;
        run_req(0, 5, 0, "unreach");

        // Cyclic chain 1 <-> 2 trips the cycle guard.
        set_scenario1();
        prev_tab[1] = 2;
        prev_tab[2] = 1;
        run_req(0, 1, 0, "cyclic");

        // Destination outside the active node range.
        set_scenario1();
        run_req(0, 12, 0, "range");

        // Backpressure on the second beat with a start pulse during EMIT.
        set_scenario1();
        run_req(0, 4, 2, "bp");

        // Asynchronous reset mid-EMIT, then a clean rerun.
        set_scenario1();
        @(negedge clock);
        source = 4'd0;
        destination = 4'd4;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        path_ready = 1'b1;
        waited = 0;
        while (!path_valid && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("mid_reach_emit", path_valid, 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", path_valid, 0);
        check("mid_rst_node", path_node, 0);
        check("mid_rst_last", path_last, 0);
        check("mid_rst_length", path_length, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run_req(0, 4, 0, "after_rst");

        // Randomized graphs: mostly planted chains, some fully random tables.
        for (int it = 0; it < 40; it++) begin
            n_nodes = $urandom_range(1, 15);
            for (int j = 0; j < MN; j++) prev_tab[j] = $urandom_range(0, 15);
            for (int j = 0; j < n_nodes; j++) perm[j] = j;
            for (int j = n_nodes - 1; j > 0; j--) begin
                k = $urandom_range(0, j);
                t = perm[j];
                perm[j] = perm[k];
                perm[k] = t;
            end
            plen = $urandom_range(1, n_nodes);
            for (int j = 1; j < plen; j++) prev_tab[perm[j]] = perm[j-1];
            s = perm[0];
            d = perm[plen-1];
            if ($urandom_range(0, 3) == 0) begin
                s = $urandom_range(0, 15);
                d = $urandom_range(0, 15);
            end
            run_req(s, d, 1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
